rf_wb_scheduler: RTL and testbench

Write-back scheduler and hazard scoreboard for the 32-entry register file. It sits between decode/issue, the two result producers (single-cycle ALU, variable-latency LSU) and the register file's single write port. It arbitrates that port with a registered write, tracks pending destination registers with per-register busy bits, and stalls issue on RAW and WAW hazards. It also throttles issue so that the LSU is never starved beyond a bound.

---
 rtl/rf_wb_scheduler_pkg.sv | 25 ++
 rtl/rf_scoreboard.sv | 56 +++++
 rtl/rf_wb_scheduler.sv | 109 ++++++++++
 tb/tb_rf_wb_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_scheduler_pkg.sv
// all_pkgs: shared register-file constants, write-back request type and popcount helper
//   WIDTH    - register data width
//   ADDR_W   - register address width
//   NREG     - number of architectural registers
//   wb_req_t - one producer's write-back request (valid, rd, data)
package all_pkgs;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [WIDTH-1:0]  data;
    } wb_req_t;

    function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
        logic [ADDR_W:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++) n = n + {{ADDR_W{1'b0}}, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, RAW/WAW hazard check and pending count
//   clk, rst          - clock, asynchronous active-high reset
//   i_set_en/addr     - mark a destination busy (issue handshake)
//   i_clr_en/addr     - release a register (the edge the register file is written)
//   i_rs1/rs2/rd/rd_we- instruction presented at issue
//   i_chk_addr        - register whose busy bit is looked up for the write-back winner
//   o_hazard          - issue must stall on RAW or WAW
//   o_chk_busy        - busy bit of i_chk_addr
//   o_pending_cnt     - number of busy registers (registered)
module rf_scoreboard
    import all_pkgs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic              i_rd_we,
    input  logic [ADDR_W-1:0] i_chk_addr,
    output logic              o_hazard,
    output logic              o_chk_busy,
    output logic [ADDR_W:0]   o_pending_cnt
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;
    logic [ADDR_W:0] r_pending;

    // x0 is never set, so busy[0] stays 0 without a dedicated mask
    assign w_set      = (i_set_en && i_set_addr != '0) ? (NREG'(1) << i_set_addr) : '0;
    assign w_clr      = i_clr_en ? (NREG'(1) << i_clr_addr) : '0;
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

    // Registered busy only: a result written this cycle is visible to issue next cycle
    assign o_hazard   = r_busy[i_rs1] | r_busy[i_rs2] | (i_rd_we & r_busy[i_rd]);
    assign o_chk_busy = r_busy[i_chk_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= popcount(w_busy_nxt);
        end
    end

    assign o_pending_cnt = r_pending;

endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: write-back arbiter for the register-file write port plus hazard/starvation issue gating
//   clk, rst                      - clock, asynchronous active-high reset
//   i_issue_*/o_issue_ready       - decode issue handshake (rs1, rs2, rd, rd_we)
//   i_alu_*                       - single-cycle ALU result, never back-pressured
//   i_lsu_*/o_lsu_ready           - LSU result handshake
//   o_rf_wr_en/addr/data          - registered register-file write
//   o_pending_cnt                 - number of busy registers
//   o_wb_err                      - sticky write-back protocol error
module rf_wb_scheduler
    import all_pkgs::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_rs1,
    input  logic [ADDR_W-1:0] i_issue_rs2,
    input  logic [ADDR_W-1:0] i_issue_rd,
    input  logic              i_issue_rd_we,
    output logic              o_issue_ready,
    input  logic              i_alu_valid,
    input  logic [ADDR_W-1:0] i_alu_rd,
    input  logic [WIDTH-1:0]  i_alu_data,
    input  logic              i_lsu_valid,
    input  logic [ADDR_W-1:0] i_lsu_rd,
    input  logic [WIDTH-1:0]  i_lsu_data,
    output logic              o_lsu_ready,
    output logic              o_rf_wr_en,
    output logic [ADDR_W-1:0] o_rf_wr_addr,
    output logic [WIDTH-1:0]  o_rf_wr_data,
    output logic [ADDR_W:0]   o_pending_cnt,
    output logic              o_wb_err
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    wb_req_t           w_alu;
    wb_req_t           w_lsu;
    wb_req_t           w_win;
    logic              w_hazard;
    logic              w_win_busy;
    logic              w_throttle;
    logic              w_set_en;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;
    logic              r_err;
    logic [SC_W-1:0]   r_starve;

    assign w_alu = {i_alu_valid, i_alu_rd, i_alu_data};
    assign w_lsu = {i_lsu_valid, i_lsu_rd, i_lsu_data};

    // ALU cannot stall, so it always wins
    assign w_win       = i_alu_valid ? w_alu : w_lsu;
    assign o_lsu_ready = !i_alu_valid;

    assign w_throttle    = r_starve >= SC_W'(STARVE_MAX);
    assign o_issue_ready = !w_hazard && !w_throttle;
    assign w_set_en      = i_issue_valid && o_issue_ready && i_issue_rd_we;

    rf_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_set_en     (w_set_en),
        .i_set_addr   (i_issue_rd),
        .i_clr_en     (r_wr_en),
        .i_clr_addr   (r_wr_addr),
        .i_rs1        (i_issue_rs1),
        .i_rs2        (i_issue_rs2),
        .i_rd         (i_issue_rd),
        .i_rd_we      (i_issue_rd_we),
        .i_chk_addr   (w_win.rd),
        .o_hazard     (w_hazard),
        .o_chk_busy   (w_win_busy),
        .o_pending_cnt(o_pending_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_wr_en <= w_win.valid && w_win.rd != '0;
            if (w_win.valid) begin
                r_wr_addr <= w_win.rd;
                r_wr_data <= w_win.data;
            end
            // Writes to x0 are dropped; writes to a non-busy register still go through
            if (w_win.valid && (w_win.rd == '0 || !w_win_busy))
                r_err <= 1'b1;
            // Saturates at STARVE_MAX so throttle holds until the LSU gets through
            if (i_lsu_valid && !o_lsu_ready)
                r_starve <= w_throttle ? r_starve : r_starve + SC_W'(1);
            else
                r_starve <= '0;
        end
    end

    assign o_rf_wr_en   = r_wr_en;
    assign o_rf_wr_addr = r_wr_addr;
    assign o_rf_wr_data = r_wr_data;
    assign o_wb_err     = r_err;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed and randomized checks of rf_wb_scheduler against a behavioural model
module tb_rf_wb_scheduler;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [5:0]  pending_cnt;
    logic        wb_err;

    rf_wb_scheduler #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_issue_valid(issue_valid),
        .i_issue_rs1  (issue_rs1),
        .i_issue_rs2  (issue_rs2),
        .i_issue_rd   (issue_rd),
        .i_issue_rd_we(issue_rd_we),
        .o_issue_ready(issue_ready),
        .i_alu_valid  (alu_valid),
        .i_alu_rd     (alu_rd),
        .i_alu_data   (alu_data),
        .i_lsu_valid  (lsu_valid),
        .i_lsu_rd     (lsu_rd),
        .i_lsu_data   (lsu_data),
        .o_lsu_ready  (lsu_ready),
        .o_rf_wr_en   (rf_wr_en),
        .o_rf_wr_addr (rf_wr_addr),
        .o_rf_wr_data (rf_wr_data),
        .o_pending_cnt(pending_cnt),
        .o_wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: set of busy registers, pending write, starvation age, sticky error
    bit          busy_m [32];
    int          starve_m;
    bit          err_m;
    bit          en_m;
    logic [4:0]  addr_m;
    logic [31:0] data_m;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        starve_m = 0;
        err_m    = 1'b0;
        en_m     = 1'b0;
        addr_m   = '0;
        data_m   = '0;
    endfunction

    function automatic bit model_ready();
        return !busy_m[issue_rs1] && !busy_m[issue_rs2] && !(issue_rd_we && busy_m[issue_rd])
               && starve_m < STARVE_MAX;
    endfunction

    function automatic int model_pending();
        int n = 0;
        foreach (busy_m[i]) n += int'(busy_m[i]);
        return n;
    endfunction

    task automatic compare();
        check("issue_ready", 64'(issue_ready), 64'(model_ready()));
        check("lsu_ready", 64'(lsu_ready), 64'(!alu_valid));
        check("pending_cnt", 64'(pending_cnt), 64'(model_pending()));
        check("wb_err", 64'(wb_err), 64'(err_m));
        check("rf_wr_en", 64'(rf_wr_en), 64'(en_m));
        if (en_m) begin
            check("rf_wr_addr", 64'(rf_wr_addr), 64'(addr_m));
            check("rf_wr_data", 64'(rf_wr_data), 64'(data_m));
        end
    endtask

    function automatic void advance();
        bit          win;
        logic [4:0]  wrd;
        logic [31:0] wd;
        bit          hs;
        win = alu_valid || lsu_valid;
        wrd = alu_valid ? alu_rd : lsu_rd;
        wd  = alu_valid ? alu_data : lsu_data;
        hs  = issue_valid && issue_rd_we && issue_rd != 0 && model_ready();
        if (win && (wrd == 0 || !busy_m[wrd])) err_m = 1'b1;
        if (en_m) busy_m[addr_m] = 1'b0;
        if (hs) busy_m[issue_rd] = 1'b1;
        en_m = win && wrd != 0;
        if (win) begin
            addr_m = wrd;
            data_m = wd;
        end
        starve_m = (lsu_valid && alu_valid) ? (starve_m < STARVE_MAX ? starve_m + 1 : starve_m) : 0;
    endfunction

    // Called just after a falling edge with inputs applied; returns at the next falling edge
    task automatic cyc();
        #1;
        compare();
        advance();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rd_we = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        rst = 0;
    endtask

    bit         lsu_acc;
    int         q[$];

    initial begin
        rst = 1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_issue_ready", 64'(issue_ready), 64'(1));
        check("reset_pending", 64'(pending_cnt), 64'(0));
        check("reset_wr_en", 64'(rf_wr_en), 64'(0));
        check("reset_wr_addr", 64'(rf_wr_addr), 64'(0));
        check("reset_wr_data", 64'(rf_wr_data), 64'(0));
        check("reset_wb_err", 64'(wb_err), 64'(0));
        rst = 0;
        @(negedge clk);

        // RAW on x5 resolved by an ALU write-back
        issue(0, 0, 5);
        cyc();
        idle();
        issue(5, 0, 6);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("t1_raw_stall", 64'(issue_ready), 64'(0));
        cyc();
        alu_valid = 0;
        #1;
        check("t1_wr_en", 64'(rf_wr_en), 64'(1));
        check("t1_wr_addr", 64'(rf_wr_addr), 64'(5));
        check("t1_wr_data", 64'(rf_wr_data), 64'hDEADBEEF);
        check("t1_still_stall", 64'(issue_ready), 64'(0));
        cyc();
        #1 check("t1_dep_issue", 64'(issue_ready), 64'(1));
        cyc();
        idle();
        do_reset();

        // ALU and LSU together: ALU first, LSU next cycle
        issue(0, 0, 3);
        cyc();
        issue(0, 0, 4);
        cyc();
        idle();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
        #1;
        check("t2_pending2", 64'(pending_cnt), 64'(2));
        check("t2_lsu_blocked", 64'(lsu_ready), 64'(0));
        cyc();
        alu_valid = 0;
        #1;
        check("t2_lsu_ready", 64'(lsu_ready), 64'(1));
        check("t2_alu_addr", 64'(rf_wr_addr), 64'(3));
        check("t2_pending2b", 64'(pending_cnt), 64'(2));
        cyc();
        lsu_valid = 0;
        #1;
        check("t2_lsu_addr", 64'(rf_wr_addr), 64'(4));
        check("t2_lsu_data", 64'(rf_wr_data), 64'h22);
        check("t2_pending1", 64'(pending_cnt), 64'(1));
        cyc();
        #1;
        check("t2_pending0", 64'(pending_cnt), 64'(0));
        check("t2_no_err", 64'(wb_err), 64'(0));
        cyc();
        do_reset();

        // Starvation throttle
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
        for (int k = 0; k < STARVE_MAX; k++) begin
            #1 check("t3_pre_throttle", 64'(issue_ready), 64'(1));
            cyc();
        end
        #1 check("t3_throttled", 64'(issue_ready), 64'(0));
        cyc();
        #1 check("t3_throttled_sat", 64'(issue_ready), 64'(0));
        cyc();
        alu_valid = 0;
        #1;
        check("t3_lsu_accept", 64'(lsu_ready), 64'(1));
        check("t3_still_throttled", 64'(issue_ready), 64'(0));
        cyc();
        lsu_valid = 0;
        #1 check("t3_resume", 64'(issue_ready), 64'(1));
        cyc();
        idle();
        do_reset();

        // x0 destination and write-back to x0
        issue(0, 0, 0);
        #1 check("t4_ready_x0", 64'(issue_ready), 64'(1));
        cyc();
        idle();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
        #1 check("t4_pending0", 64'(pending_cnt), 64'(0));
        cyc();
        alu_valid = 0;
        #1;
        check("t4_no_write", 64'(rf_wr_en), 64'(0));
        check("t4_err", 64'(wb_err), 64'(1));
        cyc();
        do_reset();

        // WAW on x7
        issue(0, 0, 7);
        cyc();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        #1 check("t5_waw_stall", 64'(issue_ready), 64'(0));
        cyc();
        alu_valid = 0;
        #1;
        check("t5_waw_stall2", 64'(issue_ready), 64'(0));
        check("t5_wr_addr", 64'(rf_wr_addr), 64'(7));
        cyc();
        #1 check("t5_waw_go", 64'(issue_ready), 64'(1));
        cyc();
        idle();
        #1 check("t5_pending1", 64'(pending_cnt), 64'(1));
        cyc();
        do_reset();

        // Asynchronous reset with three busy registers and a write in flight
        issue(0, 0, 1);
        cyc();
        issue(0, 0, 2);
        cyc();
        issue(0, 0, 3);
        cyc();
        idle();
        alu_valid = 1; alu_rd = 1; alu_data = 32'hABCD;
        cyc();
        idle();
        #1;
        check("t6_pre_en", 64'(rf_wr_en), 64'(1));
        check("t6_pre_pending", 64'(pending_cnt), 64'(3));
        #1 rst = 1;
        #1;
        check("t6_rst_en", 64'(rf_wr_en), 64'(0));
        check("t6_rst_addr", 64'(rf_wr_addr), 64'(0));
        check("t6_rst_data", 64'(rf_wr_data), 64'(0));
        check("t6_rst_pending", 64'(pending_cnt), 64'(0));
        check("t6_rst_ready", 64'(issue_ready), 64'(1));
        model_reset();
        rst = 0;
        cyc();

        // Randomized traffic; LSU holds its request until accepted
        lsu_acc = 1;
        for (int it = 0; it < 3000; it++) begin
            int alu_p;
            if ($urandom_range(99) == 0) begin
                idle();
                do_reset();
                lsu_acc = 1;
            end
            alu_p = ((it / 400) % 2 == 1) ? 80 : 35;
            q.delete();
            foreach (busy_m[i]) if (busy_m[i]) q.push_back(i);
            issue_valid = $urandom_range(99) < 70;
            issue_rs1   = 5'($urandom_range(7));
            issue_rs2   = 5'($urandom_range(7));
            issue_rd    = 5'($urandom_range(7));
            issue_rd_we = $urandom_range(99) < 80;
            alu_valid   = $urandom_range(99) < alu_p;
            alu_rd      = (q.size() > 0 && $urandom_range(9) != 0) ? 5'(q[$urandom_range(q.size() - 1)])
                                                                    : 5'($urandom_range(31));
            alu_data    = $urandom;
            if (lsu_acc) begin
                lsu_valid = $urandom_range(99) < 50;
                lsu_rd    = (q.size() > 0 && $urandom_range(9) != 0) ? 5'(q[$urandom_range(q.size() - 1)])
                                                                      : 5'($urandom_range(31));
                lsu_data  = $urandom;
            end
            lsu_acc = !lsu_valid || !alu_valid;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
